bus_master_arbiter: RTL and testbench

Acquires and holds 68000 bus mastership for the PiStorm16 transaction engine using the BR/BG/BGACK three-wire handshake. It replaces manual BR driving through the Pi control register. It sits between the Pi request path and the bus-cycle state machine: the engine raises REQ, waits for GRANT, then runs its AS/DS cycles. The arbiter releases the bus when the engine is idle, or when the maximum tenure expires, so chipset DMA is not starved.

---
 rtl/bus_master_arbiter_pkg.sv | 31 +++
 rtl/bus_master_arbiter_sync2.sv | 27 ++
 rtl/bus_master_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bus_master_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_arbiter_pkg.sv
// Shared types and state encoding for the 68000 bus-mastership arbiter.
// The Pi status path decodes STATE using the ARB_* values below.
package bus_master_arbiter_pkg;

    localparam int ARB_STATE_W = 3;
    localparam int ARB_CNT_W   = 16;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE      = 3'd0,
        ARB_REQUEST   = 3'd1,
        ARB_WAIT_FREE = 3'd2,
        ARB_ACK       = 3'd3,
        ARB_OWN       = 3'd4,
        ARB_RELEASE   = 3'd5,
        ARB_GAP       = 3'd6
    } arb_state_e;

    // Synchronized copies of the active-low bus signals.
    typedef struct packed {
        logic nbg;
        logic nbgack;
        logic nas;
        logic ndtack;
    } bus_in_t;

    // The previous master is done only when AS, DTACK and BGACK are all negated.
    function automatic logic bus_free(input bus_in_t b);
        return b.nas & b.ndtack & b.nbgack;
    endfunction

endpackage

// File: rtl/bus_master_arbiter_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous bus inputs.
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    (* async_reg = "true" *) logic [WIDTH-1:0] meta_q;
    (* async_reg = "true" *) logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bus_master_arbiter.sv
// Acquires and holds 68000 bus mastership via BR/BG/BGACK for the transaction
// engine, yielding on idle or tenure expiry so chipset DMA is not starved.
module bus_master_arbiter
    import bus_master_arbiter_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_TICKS     = 16'd4096,
    parameter logic [15:0] MAX_HOLD_TICKS    = 16'd512,
    parameter logic [7:0]  RELEASE_GAP_TICKS = 8'd4
) (
    input  logic                   SYSCLK,
    input  logic                   RESET,
    input  logic                   MCCLK_FALLING,
    input  logic                   ENABLE,
    input  logic                   REQ,
    input  logic                   ENGINE_BUSY,
    input  logic                   nBG_IN,
    input  logic                   nBGACK_IN,
    input  logic                   nAS_IN,
    input  logic                   nDTACK,
    input  logic                   ERR_CLEAR,
    output logic                   nBR_OE,
    output logic                   nBGACK_OE,
    output logic                   GRANT,
    output logic                   YIELD,
    output logic                   ERROR,
    output logic [ARB_STATE_W-1:0] STATE
);

    // Counter compares are made against the post-increment value.
    localparam logic [ARB_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_TICKS - 16'd1;
    localparam logic [ARB_CNT_W-1:0] HOLD_LAST    = MAX_HOLD_TICKS - 16'd1;
    localparam logic [ARB_CNT_W-1:0] GAP_LAST     = {8'h00, RELEASE_GAP_TICKS} - 16'd1;

    bus_in_t bus_raw;
    bus_in_t bus_s;

    arb_state_e           state_q, state_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    logic [ARB_CNT_W-1:0] cnt_inc;
    logic                 nbr_q, nbr_d;
    logic                 nbgack_q, nbgack_d;
    logic                 grant_q, grant_d;
    logic                 yield_q, yield_d;
    logic                 error_q, error_d;
    logic                 timeout_hit;

    assign bus_raw = '{nbg: nBG_IN, nbgack: nBGACK_IN, nas: nAS_IN, ndtack: nDTACK};

    // Bus signals idle high, so the synchronizer resets to all-negated.
    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_sync (
        .clk_i (SYSCLK),
        .rst_i (RESET),
        .d_i   (bus_raw),
        .q_o   (bus_s)
    );

    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbr_d       = nbr_q;
        nbgack_d    = nbgack_q;
        grant_d     = grant_q;
        yield_d     = yield_q;
        timeout_hit = 1'b0;

        if (MCCLK_FALLING) begin
            case (state_q)
                ARB_IDLE: begin
                    if (ENABLE && REQ && !error_q) begin
                        nbr_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ARB_REQUEST;
                    end
                end
                ARB_REQUEST: begin
                    cnt_d = cnt_inc;
                    // Withdrawal beats a BG arriving on the same tick.
                    if (!REQ || !ENABLE) begin
                        nbr_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ARB_GAP;
                    end else if (!bus_s.nbg) begin
                        state_d = ARB_WAIT_FREE;
                    end else if (cnt_inc == TIMEOUT_LAST) begin
                        nbr_d       = 1'b0;
                        cnt_d       = '0;
                        timeout_hit = 1'b1;
                        state_d     = ARB_GAP;
                    end
                end
                ARB_WAIT_FREE: begin
                    if (!REQ || !ENABLE) begin
                        nbr_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ARB_GAP;
                    end else if (bus_free(bus_s)) begin
                        nbgack_d = 1'b1;
                        state_d  = ARB_ACK;
                    end
                end
                ARB_ACK: begin
                    nbr_d   = 1'b0;
                    grant_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_OWN;
                end
                ARB_OWN: begin
                    if (cnt_q < MAX_HOLD_TICKS) begin
                        cnt_d = cnt_inc;
                    end
                    if (cnt_d >= HOLD_LAST) begin
                        yield_d = 1'b1;
                    end
                    // A cycle in flight is never cut, even after tenure expiry.
                    if ((!REQ || yield_q || !ENABLE) && !ENGINE_BUSY) begin
                        grant_d = 1'b0;
                        state_d = ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    nbgack_d = 1'b0;
                    yield_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ARB_GAP;
                end
                ARB_GAP: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end
                default: begin
                    nbr_d    = 1'b0;
                    nbgack_d = 1'b0;
                    grant_d  = 1'b0;
                    yield_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ARB_IDLE;
                end
            endcase
        end

        // Clear is sampled every SYSCLK; a coincident timeout still wins.
        error_d = timeout_hit | (error_q & ~ERR_CLEAR);
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            nbr_q    <= 1'b0;
            nbgack_q <= 1'b0;
            grant_q  <= 1'b0;
            yield_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nbr_q    <= nbr_d;
            nbgack_q <= nbgack_d;
            grant_q  <= grant_d;
            yield_q  <= yield_d;
            error_q  <= error_d;
        end
    end

    assign nBR_OE    = nbr_q;
    assign nBGACK_OE = nbgack_q;
    assign GRANT     = grant_q;
    assign YIELD     = yield_q;
    assign ERROR     = error_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter: vector table, directed corner
// sequences and randomized ticks against a tenure-age reference model.
module tb_bus_master_arbiter;

    localparam int TO = 16;
    localparam int MH = 8;
    localparam int GP = 4;

    // Phase numbers as the status register reports them.
    localparam int PH_IDLE = 0, PH_REQUEST = 1, PH_WAIT = 2, PH_ACK = 3,
                   PH_OWN = 4, PH_REL = 5, PH_GAP = 6;

    logic       SYSCLK = 1'b0;
    logic       RESET;
    logic       MCCLK_FALLING;
    logic       ENABLE, REQ, ENGINE_BUSY;
    logic       nBG_IN, nBGACK_IN, nAS_IN, nDTACK, ERR_CLEAR;
    logic       nBR_OE, nBGACK_OE, GRANT, YIELD, ERROR;
    logic [2:0] STATE;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase plus ages counted in ticks, each age starting
    // at 1 on the tick that entered the phase.
    int m_phase, req_age, hold_age, gap_age;
    bit m_br, m_ack, m_gr, m_y, m_err;
    bit prev_both;

    always #5 SYSCLK = ~SYSCLK;

    bus_master_arbiter #(
        .TIMEOUT_TICKS     (16'd16),
        .MAX_HOLD_TICKS    (16'd8),
        .RELEASE_GAP_TICKS (8'd4)
    ) dut (
        .SYSCLK        (SYSCLK),
        .RESET         (RESET),
        .MCCLK_FALLING (MCCLK_FALLING),
        .ENABLE        (ENABLE),
        .REQ           (REQ),
        .ENGINE_BUSY   (ENGINE_BUSY),
        .nBG_IN        (nBG_IN),
        .nBGACK_IN     (nBGACK_IN),
        .nAS_IN        (nAS_IN),
        .nDTACK        (nDTACK),
        .ERR_CLEAR     (ERR_CLEAR),
        .nBR_OE        (nBR_OE),
        .nBGACK_OE     (nBGACK_OE),
        .GRANT         (GRANT),
        .YIELD         (YIELD),
        .ERROR         (ERROR),
        .STATE         (STATE)
    );

    function automatic logic [7:0] dut_vec();
        return {nBR_OE, nBGACK_OE, GRANT, YIELD, ERROR, STATE};
    endfunction

    function automatic logic [7:0] model_vec();
        return {m_br, m_ack, m_gr, m_y, m_err, 3'(m_phase)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        req_age = 0; hold_age = 0; gap_age = 0;
        m_br = 0; m_ack = 0; m_gr = 0; m_y = 0; m_err = 0;
        prev_both = 0;
    endtask

    task automatic model_abort();
        m_br    = 0;
        gap_age = 1;
        m_phase = PH_GAP;
    endtask

    task automatic model_tick();
        bit set_err;
        bit want_out;
        set_err = 0;
        case (m_phase)
            PH_IDLE: if (ENABLE && REQ && !m_err) begin
                m_br = 1; req_age = 1; m_phase = PH_REQUEST;
            end
            PH_REQUEST: begin
                req_age++;
                if (!REQ || !ENABLE) model_abort();
                else if (!nBG_IN) m_phase = PH_WAIT;
                else if (req_age == TO) begin model_abort(); set_err = 1; end
            end
            PH_WAIT: begin
                if (!REQ || !ENABLE) model_abort();
                else if (nAS_IN && nDTACK && nBGACK_IN) begin m_ack = 1; m_phase = PH_ACK; end
            end
            PH_ACK: begin
                m_br = 0; m_gr = 1; hold_age = 1; m_phase = PH_OWN;
            end
            PH_OWN: begin
                want_out = (!REQ || m_y || !ENABLE) && !ENGINE_BUSY;
                hold_age++;
                if (hold_age >= MH) m_y = 1;
                if (want_out) begin m_gr = 0; m_phase = PH_REL; end
            end
            PH_REL: begin
                m_ack = 0; m_y = 0; gap_age = 1; m_phase = PH_GAP;
            end
            PH_GAP: begin
                gap_age++;
                if (gap_age >= GP) m_phase = PH_IDLE;
            end
            default: m_phase = PH_IDLE;
        endcase
        m_err = (m_err && !ERR_CLEAR) || set_err;
    endtask

    // Inputs change only between ticks, at least 3 SYSCLKs before the strobe.
    task automatic do_tick();
        repeat (3) @(posedge SYSCLK);
        @(negedge SYSCLK);
        MCCLK_FALLING = 1'b1;
        @(posedge SYSCLK);
        #1;
        MCCLK_FALLING = 1'b0;
    endtask

    task automatic step();
        bit cur_both;
        do_tick();
        model_tick();
        check("tick", dut_vec(), model_vec());
        check("grant_inv", {7'd0, GRANT & ~(nBGACK_OE & ~nBR_OE)}, 8'd0);
        cur_both = nBR_OE & nBGACK_OE;
        check("oe_overlap", {7'd0, prev_both & cur_both}, 8'd0);
        prev_both = cur_both;
    endtask

    task automatic clear_err();
        @(negedge SYSCLK); ERR_CLEAR = 1'b1;
        @(negedge SYSCLK); ERR_CLEAR = 1'b0;
        m_err = 0;
        check("err_clear", {7'd0, ERROR}, {7'd0, m_err});
    endtask

    task automatic set_idle_inputs();
        MCCLK_FALLING = 0; ENABLE = 1; REQ = 0; ENGINE_BUSY = 0;
        nBG_IN = 1; nBGACK_IN = 1; nAS_IN = 1; nDTACK = 1; ERR_CLEAR = 0;
    endtask

    task automatic apply_reset();
        set_idle_inputs();
        RESET = 1'b1;
        repeat (3) @(posedge SYSCLK);
        @(negedge SYSCLK);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic acquire();
        REQ = 1; nBG_IN = 1; step();
        nBG_IN = 0; step();
        step();
        nBG_IN = 1; step();
    endtask

    typedef struct {
        bit         req;
        bit         nbg;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Plain acquire/own/release walk; exp = {BR,BGACK,GRANT,YIELD,ERR,STATE}.
        vecs[0]  = '{1, 1, 8'h81};
        vecs[1]  = '{1, 1, 8'h81};
        vecs[2]  = '{1, 1, 8'h81};
        vecs[3]  = '{1, 0, 8'h82};
        vecs[4]  = '{1, 0, 8'hC3};
        vecs[5]  = '{1, 1, 8'h64};
        vecs[6]  = '{1, 1, 8'h64};
        vecs[7]  = '{0, 1, 8'h45};
        vecs[8]  = '{0, 1, 8'h06};
        vecs[9]  = '{0, 1, 8'h06};
        vecs[10] = '{0, 1, 8'h06};
        vecs[11] = '{0, 1, 8'h00};
        vecs[12] = '{0, 1, 8'h00};

        apply_reset();
        #1;
        check("reset", dut_vec(), 8'h00);

        for (int i = 0; i < 13; i++) begin
            REQ = vecs[i].req;
            nBG_IN = vecs[i].nbg;
            step();
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // BG arrives while the previous master still drives AS.
        REQ = 1; step();
        check("t2_req", {5'd0, STATE}, 8'd1);
        nBG_IN = 0; nAS_IN = 0; step();
        check("t2_wait0", {5'd0, STATE}, 8'd2);
        step();
        check("t2_wait1", {nBGACK_OE, 4'd0, STATE}, 8'h02);
        step();
        check("t2_wait2", {nBGACK_OE, 4'd0, STATE}, 8'h02);
        nAS_IN = 1; step();
        check("t2_ack", {nBGACK_OE, 4'd0, STATE}, 8'h83);
        nBG_IN = 1; step();
        REQ = 0;
        repeat (5) step();
        check("t2_done", {5'd0, STATE}, 8'd0);

        // BG timeout, with a coincident ERR_CLEAR that must not win.
        REQ = 1; nBG_IN = 1;
        for (int t = 1; t <= TO; t++) begin
            if (t == TO) ERR_CLEAR = 1;
            step();
            ERR_CLEAR = 0;
            if (t == TO - 1) check("t3_pre", {nBR_OE, ERROR, 6'd0}, 8'h80);
            if (t == TO)     check("t3_abort", {nBR_OE, ERROR, 3'd0, STATE}, 8'h46);
        end
        repeat (8) step();
        check("t3_blocked", {nBR_OE, 4'd0, STATE}, 8'h00);
        clear_err();
        step();
        check("t3_rereq", {nBR_OE, 4'd0, STATE}, 8'h81);
        REQ = 0;
        repeat (4) step();

        // Tenure expiry with the engine busy across the yield point.
        acquire();
        for (int t = 2; t <= 15; t++) begin
            ENGINE_BUSY = (t == 8 || t == 9);
            step();
            if (t == 7)  check("t4_noyield", {7'd0, YIELD}, 8'd0);
            if (t == 8)  check("t4_yield", {6'd0, YIELD, GRANT}, 8'd3);
            if (t == 9)  check("t4_busy", {7'd0, GRANT}, 8'd1);
            if (t == 10) check("t4_release", {GRANT, 4'd0, STATE}, 8'h05);
            if (t == 11) check("t4_bgack", {nBGACK_OE, 4'd0, STATE}, 8'h06);
            if (t == 13) check("t4_gap", {5'd0, STATE}, 8'd6);
            if (t == 14) check("t4_idle", {5'd0, STATE}, 8'd0);
            if (t == 15) check("t4_rereq", {nBR_OE, 4'd0, STATE}, 8'h81);
        end
        ENGINE_BUSY = 0;

        // REQ withdrawn on the tick BG arrives.
        nBG_IN = 0; REQ = 0; step();
        check("t5_abort", {nBR_OE, nBGACK_OE, 3'd0, STATE}, 8'h06);
        nBG_IN = 1;
        for (int t = 0; t < 3; t++) begin
            step();
            check("t5_noack", {7'd0, nBGACK_OE}, 8'd0);
        end
        check("t5_idle", {5'd0, STATE}, 8'd0);

        // Asynchronous reset while owning the bus.
        ENGINE_BUSY = 1;
        acquire();
        step();
        check("t6_own", {GRANT, 4'd0, STATE}, 8'h84);
        @(posedge SYSCLK);
        #3;
        RESET = 1'b1;
        #1;
        check("t6_async", {nBR_OE, nBGACK_OE, GRANT, 2'd0, STATE}, 8'h00);
        apply_reset();

        // Randomized ticks; the middle segment favours long BG waits.
        for (int i = 0; i < 420; i++) begin
            if (i >= 140 && i < 280) begin
                ENABLE = 1;
                REQ = ($urandom_range(0, 31) != 0);
                nBG_IN = ($urandom_range(0, 31) != 0);
            end else begin
                ENABLE = ($urandom_range(0, 9) != 0);
                REQ = ($urandom_range(0, 3) != 0);
                nBG_IN = $urandom_range(0, 1);
            end
            ENGINE_BUSY = ($urandom_range(0, 2) == 0);
            nAS_IN = ($urandom_range(0, 3) != 0);
            nDTACK = ($urandom_range(0, 3) != 0);
            nBGACK_IN = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) clear_err();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
